// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: state encoding, default baud divisor, frame lengths.
// The optional parity bit is enabled by defining UART_TX_PARITY_EN.
package fifo_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, pulses tick on the last count, and holds at 0 while clear is high.
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an upstream FIFO and sends them LSB-first as 8N1 serial frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              r_en,
    output logic              tx,
    output logic              busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              armed_q, armed_d;
    logic              baud_clear;
    logic              baud_tick;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Counter is held in IDLE/LOAD so START always begins with a full bit-time.
    assign baud_clear = (state_q == IDLE) || (state_q == LOAD);
    assign armed_d    = 1'b1;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    // tx_d is the line level for the state being entered, so tx is a clean flop output.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        r_en      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (armed_q && !empty) begin
                    r_en    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d   = fifo_data;
                bit_idx_d = '0;
                tx_d      = 1'b0;
                state_d   = START;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^fifo_data;
`endif
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // armed_q keeps r_en low until the first clock after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            armed_q   <= armed_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised scoreboard bench for fifo_uart_tx with a behavioural FIFO upstream and a serial-line decoder.
// Compile with UART_TX_PARITY_EN defined to exercise the parity build.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_BUSY = 1 + NB * CPB;

    logic       clk;
    logic       rst;
    logic       empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       r_en;
    logic       tx;
    logic       busy;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       corrupt = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_ren = -100;
    int ren_count = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .fifo_data(fifo_data),
        .r_en     (r_en),
        .tx       (tx),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO: read data appears the cycle after r_en; optionally scrambles data on other cycles.
    always @(posedge clk) begin
        if (r_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        else if (corrupt) fifo_data <= 8'($urandom);
        if (wr_en) fifo_q.push_back(wr_data);
        empty <= (fifo_q.size() == 0);
    end

    function automatic logic [NB-1:0] make_frame(input logic [7:0] d);
        logic [NB-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // r_en legality: never while empty, never two cycles in a row.
    logic prev_ren = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (r_en && (empty || prev_ren)) begin
                bad++;
                $display("FAIL r_en_pulse: r_en=%0b empty=%0b prev_r_en=%0b at cycle %0d", r_en, empty, prev_ren, cyc);
            end
            prev_ren = r_en;
            if (r_en) begin
                ren_count++;
                last_ren = cyc;
            end
        end else begin
            prev_ren = 1'b0;
        end
    end

    // Busy run length per frame, and single idle cycle between frames when more data waits.
    int  blen = 0;
    int  gap = 0;
    bit  gap_chk = 0;
    always @(negedge clk) begin
        if (!rst) begin
            blen = 0; gap = 0; gap_chk = 0;
        end else if (busy) begin
            if (gap > 0 && gap_chk) begin
                total++;
                if (gap != 1) begin
                    bad++;
                    $display("FAIL idle_gap: got %0d idle cycles, want 1", gap);
                end
            end
            gap = 0; gap_chk = 0;
            blen++;
        end else begin
            if (blen > 0) begin
                total++;
                if (blen != FRAME_BUSY) begin
                    bad++;
                    $display("FAIL busy_len: got %0d cycles, want %0d", blen, FRAME_BUSY);
                end
                gap_chk = !empty;
            end
            blen = 0;
            gap++;
        end
    end

    // Line decoder: on each start edge pop the expected byte and check every cycle of the frame.
    initial begin : monitor
        logic          prev_tx;
        logic [7:0]    exp_b;
        logic [NB-1:0] fr;
        bit            aborted;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_tx = 1'b1;
            end else if (prev_tx && !tx) begin
                total++;
                if (cyc - last_ren != 2) begin
                    bad++;
                    $display("FAIL start_latency: got %0d cycles after r_en, want 2", cyc - last_ren);
                end
                exp_b = 8'h00;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame: got a start bit, want none");
                end else begin
                    exp_b = exp_q.pop_front();
                end
                fr = make_frame(exp_b);
                aborted = 0;
                for (int b = 0; b < NB && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (!(b == 0 && c == 0)) begin
                            @(negedge clk);
                            if (!rst) aborted = 1;
                        end
                        if (!aborted) begin
                            total++;
                            if (tx !== fr[b]) begin
                                bad++;
                                $display("FAIL tx_bit: byte %02h bit %0d cycle %0d got %0b want %0b", exp_b, b, c, tx, fr[b]);
                            end
                        end
                    end
                end
                prev_tx = 1'b1;
            end else begin
                prev_tx = tx;
            end
        end
    end

    task automatic write_bytes(input logic [7:0] b[$]);
        foreach (b[i]) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = b[i];
            exp_q.push_back(b[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy || !empty) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (n >= 5000) begin
            total++; bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles", n);
        end
    endtask

    initial begin : stim
        logic [7:0] q[$];
        int mark;
        int n;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || r_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: tx=%0b busy=%0b r_en=%0b, want 1 0 0", tx, busy, r_en);
        end
        rst = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if (r_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_empty: r_en=%0b tx=%0b busy=%0b, want 0 1 0", r_en, tx, busy);
            end
        end

        mark = ren_count;
        q = '{8'hA5};
        write_bytes(q);
        wait_idle();
        total++;
        if (ren_count - mark != 1) begin
            bad++;
            $display("FAIL single_pop: got %0d r_en pulses, want 1", ren_count - mark);
        end

        mark = ren_count;
        q = '{8'h10, 8'h20, 8'h30, 8'h40};
        write_bytes(q);
        wait_idle();
        total++;
        if (ren_count - mark != 4 || empty !== 1'b1) begin
            bad++;
            $display("FAIL burst_pop: got %0d pulses empty=%0b, want 4 pulses empty=1", ren_count - mark, empty);
        end

        q = '{8'h07};
        write_bytes(q);
        wait_idle();

        // Reset in the middle of data bit 3 of 8'hFF.
        q = '{8'hFF};
        write_bytes(q);
        n = 0;
        while (!r_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL reset_wait: got no r_en in %0d cycles, want one", n);
        end
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || r_en !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: tx=%0b busy=%0b r_en=%0b, want 1 0 0", tx, busy, r_en);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        q = '{8'h5A};
        write_bytes(q);
        wait_idle();

        corrupt = 1'b1;
        q = '{8'h3C};
        write_bytes(q);
        wait_idle();

        for (int k = 0; k < 12; k++) begin
            q.delete();
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) q.push_back(8'($urandom));
            write_bytes(q);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_idle();
        corrupt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
